// File: rtl/mul_exec_unit_if.sv
// Execute-stage multiply port bundle: request side from the register file read
// ports, result side toward the register file write port.
interface mul_exec_unit_if #(parameter int WIDTH = 64);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] busa;
  logic [WIDTH-1:0] busb;
  logic [4:0]       rd;
  logic             flush;
  logic             busy;
  logic [WIDTH-1:0] busw;
  logic [4:0]       rw;
  logic             regwr;

  modport master (
    output start, op, busa, busb, rd, flush,
    input  busy, busw, rw, regwr
  );

  modport slave (
    input  start, op, busa, busb, rd, flush,
    output busy, busw, rw, regwr
  );
endinterface

// File: rtl/mul_exec_unit.sv
// Iterative shift-add multiplier (MUL / UMULH / SMULH), one multiplier bit per
// cycle, writing its result to the register file for a single cycle.
//
// state | meaning
// IDLE  | waiting for start; operands captured on start
// RUN   | WIDTH shift-add iterations
// FIX   | sign correction and result select
// WB    | regwr pulse
module mul_exec_unit #(
  parameter int WIDTH = 64
) (
  input logic           clk,
  input logic           reset_n,
  mul_exec_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, WB} state_t;

  state_t             state;
  logic [2*WIDTH:0]   acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               neg;
  logic [1:0]         op_q;
  logic [4:0]         rd_q;
  logic [WIDTH-1:0]   busw_q;
  logic [4:0]         rw_q;
  logic               regwr_q;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;

  // The most negative operand negates to itself, which read as unsigned is 2^(WIDTH-1).
  always_comb begin
    abs_a = bus.busa[WIDTH-1] ? (~bus.busa + WIDTH'(1)) : bus.busa;
    abs_b = bus.busb[WIDTH-1] ? (~bus.busb + WIDTH'(1)) : bus.busb;
    sum   = acc[2*WIDTH:WIDTH] + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    prod  = neg ? (~acc[2*WIDTH-1:0] + (2*WIDTH)'(1)) : acc[2*WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      op_q    <= '0;
      rd_q    <= '0;
      busw_q  <= '0;
      rw_q    <= '0;
      regwr_q <= 1'b0;
    end else begin
      regwr_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            op_q <= bus.op;
            rd_q <= bus.rd;
            acc  <= '0;
            cnt  <= '0;
            if (bus.op == 2'b10) begin
              mcand  <= abs_a;
              mplier <= abs_b;
              neg    <= bus.busa[WIDTH-1] ^ bus.busb[WIDTH-1];
            end else begin
              mcand  <= bus.busa;
              mplier <= bus.busb;
              neg    <= 1'b0;
            end
            state <= RUN;
          end
        end
        RUN: begin
          if (bus.flush) begin
            state <= IDLE;
          end else begin
            acc    <= {1'b0, sum, acc[WIDTH-1:1]};
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (cnt == CNT_LAST) state <= FIX;
          end
        end
        FIX: begin
          if (bus.flush) begin
            state <= IDLE;
          end else begin
            busw_q  <= (op_q == 2'b01 || op_q == 2'b10) ? prod[2*WIDTH-1:WIDTH]
                                                         : prod[WIDTH-1:0];
            rw_q    <= rd_q;
            regwr_q <= 1'b1;
            state   <= WB;
          end
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = (state != IDLE);
  assign bus.busw  = busw_q;
  assign bus.rw    = rw_q;
  assign bus.regwr = regwr_q;

endmodule

// File: tb/tb_mul_exec_unit.sv
// Directed and randomized checks of mul_exec_unit against a wide-arithmetic
// reference of the three multiply forms.
module tb_mul_exec_unit;

  localparam int W = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   passed = 0;
  int   total = 0;

  mul_exec_unit_if #(.WIDTH(W)) bus ();

  mul_exec_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [1:0] op, input logic [63:0] a,
                                        input logic [63:0] b);
    logic [127:0]        pu;
    logic signed [127:0] ps;
    pu = {64'd0, a} * {64'd0, b};
    ps = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
    case (op)
      2'b01:   return pu[127:64];
      2'b10:   return ps[127:64];
      default: return pu[63:0];
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic run_op(input string tag, input logic [1:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd);
    logic [63:0] exp;
    int k;
    int busy_cnt;
    exp = model(op, a, b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.busa = a; bus.busb = b; bus.rd = rd;
    @(negedge clk);
    bus.start = 1'b0; bus.busa = rnd64(); bus.busb = rnd64(); bus.rd = 5'($urandom);
    bus.op = 2'($urandom);
    busy_cnt = bus.busy ? 1 : 0;
    k = 0;
    while (!bus.regwr && k < 200) begin
      @(negedge clk);
      k++;
      if (bus.busy) busy_cnt++;
    end
    check({tag, " latency"}, 64'(k), 64'd65);
    check({tag, " busw"}, bus.busw, exp);
    check({tag, " rw"}, 64'(bus.rw), 64'(rd));
    @(negedge clk);
    check({tag, " regwr pulse"}, 64'(bus.regwr), 64'd0);
    check({tag, " busy cycles"}, 64'(busy_cnt + (bus.busy ? 1 : 0)), 64'd66);
    check({tag, " busw hold"}, bus.busw, exp);
  endtask

  task automatic count_writes(input int cycles, output int n, output logic [63:0] last);
    n = 0;
    last = '0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.regwr) begin
        n++;
        last = bus.busw;
      end
    end
  endtask

  initial begin
    int n;
    logic [63:0] last;
    logic [1:0]  rop;
    logic [63:0] ra, rb;

    bus.start = 1'b0; bus.op = 2'b00; bus.busa = '0; bus.busb = '0;
    bus.rd = '0; bus.flush = 1'b0;

    repeat (3) @(negedge clk);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset regwr", 64'(bus.regwr), 64'd0);
    check("reset busw", bus.busw, 64'd0);
    check("reset rw", 64'(bus.rw), 64'd0);
    reset_n = 1'b1;

    run_op("mul 3x5", 2'b00, 64'd3, 64'd5, 5'd2);
    run_op("umulh ones", 2'b01, '1, '1, 5'd19);
    run_op("mul ones", 2'b00, '1, '1, 5'd19);
    run_op("smulh -1x1", 2'b10, '1, 64'd1, 5'd7);
    run_op("smulh minneg", 2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd8);
    run_op("umulh minneg", 2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd9);
    run_op("mul op11 rd31", 2'b11, 64'h1234_5678_9abc_def0, 64'hfedc_ba98_7654_3210, 5'd31);

    // Start held while busy must not launch a second operation
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.busa = 64'd7; bus.busb = 64'd6; bus.rd = 5'd5;
    @(negedge clk);
    bus.busa = 64'd9;
    repeat (10) @(negedge clk);
    bus.start = 1'b0;
    count_writes(100, n, last);
    check("held start writes", 64'(n), 64'd1);
    check("held start busw", last, 64'd42);

    // Flush wins over start in IDLE
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.busa = 64'd3; bus.busb = 64'd3;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    check("flush prio busy", 64'(bus.busy), 64'd0);

    // Flush mid-RUN
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.busa = 64'd5; bus.busb = 64'd5; bus.rd = 5'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (29) @(negedge clk);
    check("flush pre busy", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush busy drop", 64'(bus.busy), 64'd0);
    count_writes(80, n, last);
    check("flush no write", 64'(n), 64'd0);
    run_op("after flush 2x2", 2'b00, 64'd2, 64'd2, 5'd4);

    // Asynchronous reset mid-RUN
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.busa = 64'd11; bus.busb = 64'd13; bus.rd = 5'd6;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async rst busy", 64'(bus.busy), 64'd0);
    check("async rst regwr", 64'(bus.regwr), 64'd0);
    check("async rst busw", bus.busw, 64'd0);
    check("async rst rw", 64'(bus.rw), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    count_writes(80, n, last);
    check("post rst no write", 64'(n), 64'd0);

    for (int i = 0; i < 12; i++) begin
      rop = 2'($urandom);
      ra  = rnd64();
      rb  = rnd64();
      if (i % 4 == 1) ra = 64'($urandom_range(0, 1000));
      if (i % 4 == 2) rb = -64'($urandom_range(1, 1000));
      run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, 5'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
